// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and helpers for the parametrised FIFO family
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DATA_W x DEPTH storage array, sync write / async read
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset: contents survive a FIFO reset and are only ever read
  // through pointers that guarantee the slot was written first.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO; SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  // Pointers carry an extra wrap bit; low AW bits address the array.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, empty_q, af_q, ae_q;
  logic        ovf_q, unf_q;
  logic        wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // A write into a full FIFO is allowed when a read frees a slot in the
  // same cycle; a read of an empty FIFO is never allowed, even alongside
  // a write, because the word is not yet in the array.
  assign wr_acc = wr_en & (~full_q | rd_en);
  assign rd_acc = rd_en & ~empty_q;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Next-state pointers and occupancy from the accepted operations.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Control state; flags come from count_d so they line up with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= wr_en & ~wr_acc;
      unf_q    <= rd_en & ~rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is always on the output; rd_en only pops it.
  assign rd_data  = mem_rdata;
  assign rd_valid = ~empty_q;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Registered read: data lands one clock after an accepted rd_en and
  // then holds until the next accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param default build
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;

  sync_fifo_param dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status(input logic eovf, input logic eunf);
    int n;
    n = model_q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == 16));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= 14));
    check("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check("overflow", 32'(overflow), 32'(eovf));
    check("underflow", 32'(underflow), 32'(eunf));
  endtask

  // One clock: drive, update model/scoreboard, sample 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    logic wacc, racc;
    int n;
    n = model_q.size();
    wacc = we && ((n < 16) || re);
    racc = re && (n > 0);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_status(we && !wacc, re && !racc);
    check("rd_valid", 32'(rd_valid), 32'(racc));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(1), 32'(0));
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(last_rd));
      end
    end else begin
      check("rd_data_hold", 32'(rd_data), 32'(last_rd));
    end
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    last_rd = 8'h00;
    check_status(1'b0, 1'b0);
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_status(1'b0, 1'b0);
    check("reset_rd_valid", 32'(rd_valid), 32'(0));
    check("reset_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);

    // Partial fill then asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
    async_reset();

    // Fill to full, then an overflowing write.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Drain all 16, then an underflowing read.
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("hold_after_underflow", 32'(rd_data), 32'h0F);

    // Simultaneous write/read on empty: write only, underflow.
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Refill, then simultaneous write/read while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    check("full_pass_data", 32'(rd_data), 32'h00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

    // Streaming at constant occupancy 3 across two pointer wraps.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 3; i < 43; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Random mix against the model.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit x 16 buffer.
- Adds configurable width and depth, simultaneous read and write in one cycle, and an occupancy count.
- Adds programmable almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Sits between byte/word producers and consumers in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a newly read word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  occupancy 0..DEPTH, where AW = clog2(DEPTH).
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset: single clock domain; rst is asynchronous and active-low.
  - While rst=0: pointers=0, count=0, rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all contents immediately; the first edge after release behaves as from empty.
- Pointers: wr_ptr and rd_ptr are AW+1 bits, with the MSB as the wrap bit; the low AW bits address memory. Wrap from DEPTH-1 to 0 is natural binary rollover.
- Acceptance, evaluated on pre-edge flags:
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
  - When full with wr_en & rd_en: both are accepted; count stays at DEPTH and the oldest word is read.
  - When empty with wr_en & rd_en: only the write is accepted, underflow pulses, count becomes 1.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read (standard mode): on rd_acc, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 on the following cycle. Latency is 1 clock. rd_data holds its value otherwise, and rd_valid=0.
- Count: count <= count + wr_acc - rd_acc. All status flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
- Errors: overflow <= wr_en & ~wr_acc; underflow <= rd_en & ~rd_acc. Both are single-cycle pulses, not sticky. State does not change on rejected operations.
- Back-to-back operation: one read and/or one write per cycle, sustained indefinitely with no bubbles.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - rd_data continuously presents mem[rd_ptr] combinationally.
  - rd_valid = ~empty.
  - rd_en acts as a pop acknowledge; the next word appears in the cycle after the pop.
  - A word written into an empty FIFO is visible on the cycle after the write.
  - Reset value of rd_valid is 0.
- Undefined: standard registered read as specified under Behaviour.

Decomposition:
- Package fifo_pkg:
  - clog2 function.
  - Default constants FIFO_DATA_W_DEF=8 and FIFO_DEPTH_DEF=16.
- Sub-module fifo_mem_2p:
  - DATA_W x DEPTH register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - No reset on the array.
  - Control, pointers and flags stay in sync_fifo_param.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, all others 0. Assert rst=0 mid-fill at count=5 -> count=0 and empty=1 asynchronously.
- Write 0x00..0x0F (DEFAULTS) -> count 1..16; almost_full at count=14; full=1 at 16. A 17th write of 0xAA -> overflow pulse, count stays 16.
- Read 16 words after fill -> rd_data 0x00..0x0F, each one cycle after rd_en, with rd_valid pulses. Then empty=1; a further read gives underflow, rd_data stays 0x0F.
- At count=16, assert wr_en=1 (0x55) and rd_en=1 for 1 cycle -> rd_data=0x00, count=16, no overflow. At count=0 with both asserted -> count=1, underflow=1.
- Wrap-around: write/read 40 words streaming with simultaneous wr_en/rd_en and count held at 3 -> data in order, no errors, pointers wrap twice.
- FWFT build: write 0x3C into an empty FIFO -> next cycle rd_valid=1, rd_data=0x3C without rd_en. Pop -> rd_valid=0.
